// File: rtl/multi_key_decoder.sv
// Tracks NUM_KEYS PS/2 keys from the make/breakk/key_code stream: held level, press/release pulses, hold frames.
// Optional hold counters are built only when MULTI_KEY_DECODER_HOLD_EN is defined; otherwise holdCount is 0.
module multi_key_decoder #(
    parameter int                    NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h05A, 9'h029, 9'h059, 9'h012},
    parameter int                    HOLD_W    = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [8:0]                 key_code,
    input  logic                       make,
    input  logic                       breakk,
    input  logic                       startOfFrame,
    output logic [NUM_KEYS-1:0]        keyIsPressed,
    output logic [NUM_KEYS-1:0]        keyPressPulse,
    output logic [NUM_KEYS-1:0]        keyReleasePulse,
    output logic [NUM_KEYS*HOLD_W-1:0] holdCount
);

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_PRESSED  = 1'b1
    } key_state_e;

    key_state_e          state_q [NUM_KEYS];
    key_state_e          state_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            hit[i] = (key_code == KEY_CODES[9*i +: 9]);
        end
    end

    // Break has priority over a coincident make on the same channel.
    always_comb begin
        press_d = '0;
        rel_d   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                KEY_RELEASED: begin
                    if (hit[i] && make && !breakk) begin
                        state_d[i] = KEY_PRESSED;
                        press_d[i] = 1'b1;
                    end
                end
                KEY_PRESSED: begin
                    if (hit[i] && breakk) begin
                        state_d[i] = KEY_RELEASED;
                        rel_d[i]   = 1'b1;
                    end
                end
                default: state_d[i] = KEY_RELEASED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= KEY_RELEASED;
            end
            press_q <= '0;
            rel_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
            end
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        keyIsPressed = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            keyIsPressed[i] = (state_q[i] == KEY_PRESSED);
        end
    end

    assign keyPressPulse   = press_q;
    assign keyReleasePulse = rel_q;

`ifdef MULTI_KEY_DECODER_HOLD_EN
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;

    logic [HOLD_W-1:0] hold_q [NUM_KEYS];
    logic [HOLD_W-1:0] hold_d [NUM_KEYS];

    // Only frames fully inside the held interval count: not the press cycle, not the release cycle.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            hold_d[i] = hold_q[i];
            if (press_d[i]) begin
                hold_d[i] = '0;
            end else if (startOfFrame && (state_q[i] == KEY_PRESSED) &&
                         (state_d[i] == KEY_PRESSED) && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    always_comb begin
        holdCount = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            holdCount[HOLD_W*i +: HOLD_W] = hold_q[i];
        end
    end
`else
    logic unused_sof;
    assign unused_sof = startOfFrame;
    assign holdCount  = '0;
`endif

endmodule

// File: tb/tb_multi_key_decoder.sv
// Randomised and directed bench for multi_key_decoder against a per-key behavioural model.
// Hold expectations follow MULTI_KEY_DECODER_HOLD_EN, matching the RTL build.
module tb_multi_key_decoder;

    localparam int NK = 4;
    localparam int HW = 3;
    localparam int HMAX = (1 << HW) - 1;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic [8:0]        key_code = '0;
    logic              make = 1'b0;
    logic              breakk = 1'b0;
    logic              startOfFrame = 1'b0;
    logic [NK-1:0]     keyIsPressed;
    logic [NK-1:0]     keyPressPulse;
    logic [NK-1:0]     keyReleasePulse;
    logic [NK*HW-1:0]  holdCount;

    multi_key_decoder #(
        .NUM_KEYS (NK),
        .HOLD_W   (HW)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .key_code        (key_code),
        .make            (make),
        .breakk          (breakk),
        .startOfFrame    (startOfFrame),
        .keyIsPressed    (keyIsPressed),
        .keyPressPulse   (keyPressPulse),
        .keyReleasePulse (keyReleasePulse),
        .holdCount       (holdCount)
    );

    always #5 clk = ~clk;

    // Key table: L-shift, R-shift, space, enter by channel index.
    logic [8:0] key_tbl [NK] = '{9'h012, 9'h059, 9'h029, 9'h05A};

    bit            m_held [NK];
    int            m_cnt  [NK];
    logic [NK-1:0] e_press;
    logic [NK-1:0] e_rel;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [NK-1:0]    e_held;
        logic [NK*HW-1:0] e_hold;
        e_held = '0;
        e_hold = '0;
        for (int i = 0; i < NK; i++) begin
            e_held[i] = m_held[i];
`ifdef MULTI_KEY_DECODER_HOLD_EN
            e_hold[HW*i +: HW] = m_cnt[i][HW-1:0];
`endif
        end
        check({tag, ".held"},  32'(keyIsPressed),    32'(e_held));
        check({tag, ".press"}, 32'(keyPressPulse),   32'(e_press));
        check({tag, ".rel"},   32'(keyReleasePulse), 32'(e_rel));
        check({tag, ".hold"},  32'(holdCount),       32'(e_hold));
    endtask

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_held[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        e_press = '0;
        e_rel   = '0;
    endtask

    // One clock of the key rules as written: a break on a held key releases it,
    // a make on a free key presses it, otherwise held keys count frames up to the ceiling.
    task automatic model_step(input logic mk, input logic bk, input logic [8:0] code, input logic sof);
        e_press = '0;
        e_rel   = '0;
        for (int i = 0; i < NK; i++) begin
            if (code == key_tbl[i] && bk) begin
                if (m_held[i]) begin
                    m_held[i] = 1'b0;
                    e_rel[i]  = 1'b1;
                end
            end else if (code == key_tbl[i] && mk && !m_held[i]) begin
                m_held[i]  = 1'b1;
                m_cnt[i]   = 0;
                e_press[i] = 1'b1;
            end else if (m_held[i] && sof) begin
                m_cnt[i] = (m_cnt[i] < HMAX) ? m_cnt[i] + 1 : HMAX;
            end
        end
    endtask

    task automatic step(input string tag, input logic mk, input logic bk,
                        input logic [8:0] code, input logic sof);
        key_code     = code;
        make         = mk;
        breakk       = bk;
        startOfFrame = sof;
        model_step(mk, bk, code, sof);
        @(posedge clk);
        #1;
        make         = 1'b0;
        breakk       = 1'b0;
        startOfFrame = 1'b0;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        resetN       = 1'b0;
        key_code     = 9'(($urandom_range(0, 3) == 0) ? 9'h012 : $urandom_range(0, 511));
        make         = 1'($urandom_range(0, 1));
        breakk       = 1'($urandom_range(0, 1));
        startOfFrame = 1'($urandom_range(0, 1));
        model_reset();
        @(posedge clk);
        #1;
        resetN       = 1'b1;
        make         = 1'b0;
        breakk       = 1'b0;
        startOfFrame = 1'b0;
        compare_all(tag);
    endtask

    initial begin
        logic [8:0] code;
        logic       mk, bk, sof;

        #2;
        do_reset("reset");

        step("press012",  1, 0, 9'h012, 0);
        step("idle0",     0, 0, 9'h000, 0);
        step("break012",  1'b0, 1'b1, 9'h012, 0);
        step("idle1",     0, 0, 9'h000, 0);

        step("press059",  1, 0, 9'h059, 0);
        for (int k = 0; k < 3; k++) step("repeat059", 1, 0, 9'h059, 0);
        step("orphan029", 0, 1, 9'h029, 0);
        step("ext112",    1, 0, 9'h112, 0);
        step("break059",  0, 1, 9'h059, 0);

        step("two_a",     1, 0, 9'h012, 0);
        step("two_b",     1, 0, 9'h05A, 0);
        step("two_c",     0, 1, 9'h012, 0);

        step("hold_press", 1, 0, 9'h029, 1);
        for (int k = 0; k < 10; k++) step("hold_sof", 0, 0, 9'h000, 1);
        step("hold_rel",   0, 1, 9'h029, 1);
        for (int k = 0; k < 2; k++) step("hold_frozen", 0, 0, 9'h000, 1);
        step("hold_repress", 1, 0, 9'h029, 0);
        step("hold_sof2",    0, 0, 9'h000, 1);

        step("mk_bk_05A",  1, 1, 9'h05A, 0);
        step("mk_bk_idle", 1, 1, 9'h05A, 0);
        step("sof_mid",    0, 0, 9'h000, 1);
        do_reset("reset_mid");
        step("post_reset", 0, 0, 9'h000, 1);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: code = key_tbl[$urandom_range(0, NK-1)];
                4:          code = key_tbl[$urandom_range(0, NK-1)] | 9'h100;
                default:    code = 9'($urandom_range(0, 511));
            endcase
            mk  = ($urandom_range(0, 2) == 0);
            bk  = ($urandom_range(0, 3) == 0);
            sof = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) do_reset("rnd_reset");
            else step("rnd", mk, bk, code, sof);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
